// File: rtl/sequence_playback_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sequence_playback_ctrl_pkg
// Brief   : Shared state encodings and widths for the Genius sequence player.
// Revision: 1.0 - initial release
// ============================================================================
package sequence_playback_ctrl_pkg;

   localparam int SYM_W = 2;
   localparam int IDX_W = 4;

   // Shared with the game FSM and the button receiver, so the encodings are fixed.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_ON    = 3'd2;
   localparam logic [2:0] ST_GAP   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sequence_playback_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sequence_playback_ctrl_if
// Brief   : Control, ROM and display signals of the sequence playback block.
// Revision: 1.0 - initial release
// ============================================================================
interface sequence_playback_ctrl_if;
   import sequence_playback_ctrl_pkg::*;

   logic             start;
   logic             abort;
   logic [IDX_W-1:0] level;
   logic [SYM_W-1:0] symbol_in;
   logic [IDX_W-1:0] seq_index;
   logic [SYM_W-1:0] symbol_out;
   logic             show;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, level, symbol_in,
      input  seq_index, symbol_out, show, busy, done
   );

   modport slave (
      input  start, abort, level, symbol_in,
      output seq_index, symbol_out, show, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/sequence_playback_ctrl_tick_timer.sv
`default_nettype none
// ============================================================================
// Module  : sequence_playback_ctrl_tick_timer
// Brief   : Loadable down-counter that parks at zero and flags it.
// Revision: 1.0 - initial release
// ============================================================================
module sequence_playback_ctrl_tick_timer #(
   parameter int CNT_W = 26
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             load,
   input  wire logic [CNT_W-1:0] load_val,
   output      logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/sequence_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sequence_playback_ctrl
// Brief   : Plays sequence-ROM symbols 0..level with timed show/blank phases.
// Revision: 1.0 - initial release
// ============================================================================
module sequence_playback_ctrl
   import sequence_playback_ctrl_pkg::*;
#(
   parameter int TICKS_ON  = 50_000_000,
   parameter int TICKS_OFF = 25_000_000,
   parameter int CNT_W     = 26
) (
   input  wire logic                     clock,
   input  wire logic                     reset,
   sequence_playback_ctrl_if.slave       bus
);

   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(TICKS_ON - 1);
   localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(TICKS_OFF - 1);

   logic [2:0]       state;
   logic [2:0]       next_state;
   logic [IDX_W-1:0] seq_index;
   logic [IDX_W-1:0] last_idx;
   logic [SYM_W-1:0] symbol_out;
   logic             timer_load;
   logic [CNT_W-1:0] timer_load_val;
   logic             timer_zero;

   sequence_playback_ctrl_tick_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_load_val),
      .zero     (timer_zero)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (bus.abort) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (bus.start) next_state = ST_FETCH;
            ST_FETCH: next_state = ST_ON;
            ST_ON:    if (timer_zero) next_state = ST_GAP;
            ST_GAP: begin
               // Compare before increment: level=15 ends at index 15, no wrap.
               if (timer_zero) begin
                  next_state = (seq_index == last_idx) ? ST_DONE : ST_FETCH;
               end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.show = (state == ST_ON);
      bus.busy = (state == ST_FETCH) || (state == ST_ON) || (state == ST_GAP);
      bus.done = (state == ST_DONE);
   end

   // Each timed state is entered with a fresh load, so the counter never underflows.
   always_comb begin
      timer_load     = 1'b0;
      timer_load_val = ON_LOAD;
      if (state == ST_FETCH) begin
         timer_load     = 1'b1;
         timer_load_val = ON_LOAD;
      end else if ((state == ST_ON) && timer_zero) begin
         timer_load     = 1'b1;
         timer_load_val = OFF_LOAD;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seq_index  <= '0;
         last_idx   <= '0;
         symbol_out <= '0;
      end else if (bus.abort) begin
         seq_index  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               seq_index <= '0;
               if (bus.start) last_idx <= bus.level;
            end
            ST_FETCH: symbol_out <= bus.symbol_in;
            ST_GAP: begin
               if (timer_zero && (seq_index != last_idx)) begin
                  seq_index <= seq_index + 1'b1;
               end
            end
            ST_DONE:  seq_index <= '0;
            default:  seq_index <= seq_index;
         endcase
      end
   end

   assign bus.seq_index  = seq_index;
   assign bus.symbol_out = symbol_out;

endmodule
`default_nettype wire

// File: tb/tb_sequence_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sequence_playback_ctrl
// Brief   : Self-checking bench for sequence_playback_ctrl (TICKS_ON=4, TICKS_OFF=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sequence_playback_ctrl;
   import sequence_playback_ctrl_pkg::*;

   localparam int TON  = 4;
   localparam int TOFF = 2;
   localparam int P    = 1 + TON + TOFF;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [SYM_W-1:0] rom [16];
   logic [SYM_W-1:0] exp_sym = '0;

   sequence_playback_ctrl_if intf ();

   // ROM data settles within the cycle in which the address changes.
   assign intf.symbol_in = rom[intf.seq_index];

   sequence_playback_ctrl #(
      .TICKS_ON  (TON),
      .TICKS_OFF (TOFF),
      .CNT_W     (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (intf.slave)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic expect_outs(input string tag, input logic show, input logic busy,
                              input logic done, input int idx, input logic [SYM_W-1:0] sym);
      check_val({tag, ".show"},       32'(intf.show),       32'(show));
      check_val({tag, ".busy"},       32'(intf.busy),       32'(busy));
      check_val({tag, ".done"},       32'(intf.done),       32'(done));
      check_val({tag, ".seq_index"},  32'(intf.seq_index),  32'(idx));
      check_val({tag, ".symbol_out"}, 32'(intf.symbol_out), 32'(sym));
   endtask

   // Reference timeline: t edges after the start edge, symbol s=t/P,
   // phase 0 fetch, 1..TON shown, rest blank, done exactly at t=(level+1)*P.
   task automatic play(input int lvl, input int abort_t, input bit noise);
      int total;
      int s;
      int ph;
      total = (lvl + 1) * P;
      @(negedge clock);
      intf.level = 4'(lvl);
      intf.start = 1'b1;
      intf.abort = 1'b0;
      @(posedge clock); #1;
      for (int t = 0; t <= total; t++) begin
         if (t > 0) begin
            @(negedge clock);
            intf.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) intf.level = 4'($urandom_range(0, 15));
            if (t == abort_t) intf.abort = 1'b1;
            @(posedge clock); #1;
            if (t == abort_t) begin
               expect_outs("abort", 1'b0, 1'b0, 1'b0, 0, exp_sym);
               @(negedge clock);
               intf.abort = 1'b0;
               intf.start = 1'b0;
               @(posedge clock); #1;
               expect_outs("post_abort", 1'b0, 1'b0, 1'b0, 0, exp_sym);
               return;
            end
         end
         s  = t / P;
         ph = t % P;
         if (t == total) begin
            expect_outs("done", 1'b0, 1'b0, 1'b1, lvl, exp_sym);
         end else begin
            if (ph >= 1) exp_sym = rom[s];
            expect_outs("play", (ph >= 1) && (ph <= TON), 1'b1, 1'b0, s, exp_sym);
         end
      end
      @(negedge clock);
      intf.start = noise;
      @(posedge clock); #1;
      expect_outs("idle", 1'b0, 1'b0, 1'b0, 0, exp_sym);
      @(negedge clock);
      intf.start = 1'b0;
      @(posedge clock); #1;
      expect_outs("idle2", 1'b0, 1'b0, 1'b0, 0, exp_sym);
   endtask

   task automatic start_with_abort();
      @(negedge clock);
      intf.level = 4'd5;
      intf.start = 1'b1;
      intf.abort = 1'b1;
      @(posedge clock); #1;
      expect_outs("start_abort", 1'b0, 1'b0, 1'b0, 0, exp_sym);
      @(negedge clock);
      intf.start = 1'b0;
      intf.abort = 1'b0;
      @(posedge clock); #1;
      expect_outs("start_abort2", 1'b0, 1'b0, 1'b0, 0, exp_sym);
   endtask

   task automatic reset_mid_on();
      @(negedge clock);
      intf.level = 4'd3;
      intf.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      intf.start = 1'b0;
      @(posedge clock); #1;
      check_val("pre_reset.show", 32'(intf.show), 32'd1);
      #2 reset = 1'b0;
      #1;
      exp_sym = '0;
      expect_outs("async_reset", 1'b0, 1'b0, 1'b0, 0, exp_sym);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      int lvl;
      int ab;
      for (int i = 0; i < 16; i++) rom[i] = SYM_W'(i % 4);
      intf.start = 1'b0;
      intf.abort = 1'b0;
      intf.level = '0;
      #12;
      expect_outs("reset", 1'b0, 1'b0, 1'b0, 0, '0);
      @(negedge clock);
      reset = 1'b1;

      play(0, -1, 1'b0);
      play(3, -1, 1'b0);
      play(15, -1, 1'b0);
      play(3, 10, 1'b0);
      start_with_abort();
      play(2, -1, 1'b1);
      reset_mid_on();
      play(3, -1, 1'b0);

      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 16; i++) rom[i] = SYM_W'($urandom_range(0, 3));
         lvl = $urandom_range(0, 15);
         ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (lvl + 1) * P) : -1;
         play(lvl, ab, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
